capture_write_controller: RTL and testbench

//  Write-side companion to the FIFO read controller. Arms on request, waits for a trigger edge,

---
 rtl/capture_write_controller_pkg.sv | 22 ++
 rtl/capture_write_controller_if.sv | 48 ++++
 rtl/capture_write_controller_trig_sync_edge.sv | 39 +++
 rtl/capture_write_controller.sv | 106 ++++++++++
 tb/tb_capture_write_controller.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/capture_write_controller_pkg.sv
// ============================================================================
//  Module   : adc_capture_pkg
//  Brief    : Shared state encoding and defaults for the capture write path.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package adc_capture_pkg;

    localparam int DEFAULT_NUM_CH = 6;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        ARMED   = 4'b0010,
        CAPTURE = 4'b0100,
        DONE    = 4'b1000
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/capture_write_controller_if.sv
// ============================================================================
//  Module   : capture_write_controller_if
//  Brief    : Control/FIFO-side bundle of the capture write controller.
//             Optional macro CAPTURE_TIMESTAMP_EN adds trig_timestamp.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface capture_write_controller_if #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 16
);
    logic              arm;
    logic              abort;
    logic              trig;
    logic              sample_valid;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] wr_en;
    logic              capture_done;
    logic              busy;
    logic              overflow;
    logic [CNT_W-1:0]  sample_count;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0]       trig_timestamp;

    modport slave (
        input  arm, abort, trig, sample_valid, fifo_full, fifo_empty,
        output wr_en, capture_done, busy, overflow, sample_count, trig_timestamp
    );
    modport master (
        output arm, abort, trig, sample_valid, fifo_full, fifo_empty,
        input  wr_en, capture_done, busy, overflow, sample_count, trig_timestamp
    );
`else
    modport slave (
        input  arm, abort, trig, sample_valid, fifo_full, fifo_empty,
        output wr_en, capture_done, busy, overflow, sample_count
    );
    modport master (
        output arm, abort, trig, sample_valid, fifo_full, fifo_empty,
        input  wr_en, capture_done, busy, overflow, sample_count
    );
`endif
endinterface

`default_nettype wire

// File: rtl/capture_write_controller_trig_sync_edge.sv
// ============================================================================
//  Module   : trig_sync_edge
//  Brief    : Two-flop synchroniser followed by a registered rising-edge pulse.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module trig_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_pulse
);
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_pulse;

    // Pulse lands three clocks after the pin rises: two sync stages plus the edge register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_d;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pulse <= r_s2 & ~r_s3;
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/capture_write_controller.sv
// ============================================================================
//  Module   : capture_write_controller
//  Brief    : Arms, waits for trigger, writes DEPTH aligned samples to NUM_CH FIFOs.
//             Optional macro CAPTURE_TIMESTAMP_EN latches a cycle stamp per trigger.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module capture_write_controller
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    capture_write_controller_if.slave bus
);
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(DEPTH - 1);

    cap_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_trig_edge;
    logic             w_all_empty;
    logic             w_any_full;
    logic             w_write;

    trig_sync_edge u_trig_sync (
        .clk     (clk),
        .rst     (rst),
        .i_d     (bus.trig),
        .o_pulse (w_trig_edge)
    );

    assign w_all_empty = &bus.fifo_empty;
    assign w_any_full  = |bus.fifo_full;
    // Combinational so FIFO din can come straight from the ADC path; a full FIFO stalls all channels.
    assign w_write     = (r_state == CAPTURE) & ~bus.abort & bus.sample_valid & ~w_any_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.abort) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.arm && w_all_empty) begin
                        r_state    <= ARMED;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ARMED: begin
                    if (w_trig_edge) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    if (bus.sample_valid) begin
                        if (w_any_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                            if (r_count == c_LAST_IDX) r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (w_all_empty) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.wr_en        = {NUM_CH{w_write}};
    assign bus.capture_done = (r_state == DONE);
    assign bus.busy         = (r_state == ARMED) | (r_state == CAPTURE);
    assign bus.overflow     = r_overflow;
    assign bus.sample_count = r_count;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_timestamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle     <= '0;
            r_timestamp <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if ((r_state == ARMED) && w_trig_edge && !bus.abort) r_timestamp <= r_cycle;
        end
    end

    assign bus.trig_timestamp = r_timestamp;
`endif

endmodule

`default_nettype wire

// File: tb/tb_capture_write_controller.sv
// ============================================================================
//  Module   : tb_capture_write_controller
//  Brief    : Self-checking bench for capture_write_controller against a cycle model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_capture_write_controller;

    localparam int NUM_CH = 6;
    localparam int DEPTH  = 1024;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    capture_write_controller_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    capture_write_controller #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0=idle 1=armed 2=capture 3=done
    int          m_phase;
    int          m_count;
    bit          m_ovf;
    logic [31:0] m_cycles;
    logic [31:0] m_ts;
    bit          hist[$];
    int          wr_cycles;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("busy", bus.busy, (m_phase == 1 || m_phase == 2));
        chk("capture_done", bus.capture_done, (m_phase == 3));
        chk("overflow", bus.overflow, m_ovf);
        chk("sample_count", bus.sample_count, m_count);
`ifdef CAPTURE_TIMESTAMP_EN
        chk("trig_timestamp", bus.trig_timestamp, m_ts);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.arm = 0; bus.abort = 0; bus.trig = 0; bus.sample_valid = 0;
        bus.fifo_full = '0; bus.fifo_empty = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_phase = 0; m_count = 0; m_ovf = 0; m_cycles = '0; m_ts = '0;
        hist = '{0, 0, 0, 0};
        chk("reset_wr_en", bus.wr_en, 6'h00);
        check_regs();
    endtask

    // Called at posedge+1; applies inputs for one cycle and checks both sides of the edge.
    task automatic step(input bit a, input bit ab, input bit t, input bit v,
                        input logic [5:0] full, input logic [5:0] empty);
        logic [5:0] exp_wr;
        bit         tedge;
        int         n;
        bus.arm = a; bus.abort = ab; bus.trig = t; bus.sample_valid = v;
        bus.fifo_full = full; bus.fifo_empty = empty;
        #3;
        exp_wr = (m_phase == 2 && !ab && v && full == 6'h00) ? 6'h3F : 6'h00;
        chk("wr_en", bus.wr_en, exp_wr);
        if (bus.wr_en == 6'h3F) wr_cycles++;
        @(posedge clk);
        n = hist.size();
        tedge = hist[n-3] && !hist[n-4];
        if (ab) begin
            m_phase = 0; m_count = 0;
        end else begin
            case (m_phase)
                0: if (a && empty == 6'h3F) begin m_phase = 1; m_count = 0; m_ovf = 0; end
                1: if (tedge) begin m_phase = 2; m_ts = m_cycles; end
                2: if (v) begin
                       if (full != 6'h00) m_ovf = 1;
                       else begin
                           m_count++;
                           if (m_count == DEPTH) m_phase = 3;
                       end
                   end
                default: if (empty == 6'h3F) m_phase = 0;
            endcase
        end
        m_cycles = m_cycles + 32'd1;
        hist.push_back(t);
        void'(hist.pop_front());
        #1;
        check_regs();
    endtask

    task automatic arm_and_trigger();
        step(1, 0, 0, 0, 6'h00, 6'h3F);
        repeat (2) step(0, 0, 1, 0, 6'h00, 6'h3F);
        for (int i = 0; i < 8 && m_phase != 2; i++) step(0, 0, 0, 0, 6'h00, 6'h3F);
        chk("triggered_busy", bus.busy, 1'b1);
    endtask

    task automatic run_until_done();
        for (int i = 0; i < 1200 && m_phase != 3; i++) step(0, 0, 0, 1, 6'h00, 6'h3F);
        chk("done_reached", bus.capture_done, 1'b1);
        chk("count_at_done", bus.sample_count, DEPTH);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t_cyc;
        bit          t_level;
        logic [5:0]  r_full;
        logic [5:0]  r_empty;

        do_reset();

        // Clean capture with continuous valid
        wr_cycles = 0;
        arm_and_trigger();
        run_until_done();
        chk("write_total", wr_cycles, DEPTH);

        // DONE held while any FIFO is non-empty; arm ignored in DONE
        repeat (3) step(0, 0, 0, 0, 6'h00, 6'h3E);
        step(1, 0, 0, 0, 6'h00, 6'h3E);
        chk("done_hold", bus.capture_done, 1'b1);
        step(0, 0, 0, 0, 6'h00, 6'h3F);
        step(0, 0, 0, 0, 6'h00, 6'h3F);

        // Arm refused with a non-empty FIFO; trigger edges then produce nothing
        step(1, 0, 0, 0, 6'h00, 6'h3B);
        chk("arm_refused_busy", bus.busy, 1'b0);
        repeat (3) step(0, 0, 1, 1, 6'h00, 6'h3F);
        repeat (6) step(0, 0, 0, 1, 6'h00, 6'h3F);

        // FIFO full stall mid-capture
        wr_cycles = 0;
        arm_and_trigger();
        for (int i = 0; i < 400 && m_count < 300; i++) step(0, 0, 0, 1, 6'h00, 6'h3F);
        repeat (5) step(0, 0, 0, 1, 6'h04, 6'h3F);
        chk("overflow_set", bus.overflow, 1'b1);
        run_until_done();
        chk("write_total_stall", wr_cycles, DEPTH);
        step(0, 0, 0, 0, 6'h00, 6'h3F);
        step(1, 0, 0, 0, 6'h00, 6'h3F);
        chk("overflow_cleared", bus.overflow, 1'b0);
        step(0, 1, 0, 0, 6'h00, 6'h3F);

        // Abort mid-capture, then on the terminal write
        arm_and_trigger();
        for (int i = 0; i < 600 && m_count < 500; i++) step(0, 0, 0, 1, 6'h00, 6'h3F);
        step(0, 1, 0, 1, 6'h00, 6'h3F);
        chk("abort_mid_count", bus.sample_count, 0);
        arm_and_trigger();
        for (int i = 0; i < 1100 && m_count < DEPTH - 1; i++) step(0, 0, 0, 1, 6'h00, 6'h3F);
        step(0, 1, 0, 1, 6'h00, 6'h3F);
        chk("abort_last_done", bus.capture_done, 1'b0);
        step(1, 1, 0, 0, 6'h00, 6'h3F);
        chk("arm_abort_idle", bus.busy, 1'b0);

        // Randomised traffic against the model
        t_level = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) t_level = ~t_level;
            r_full  = ($urandom_range(19) == 0) ? 6'(1 << $urandom_range(5)) : 6'h00;
            if (m_phase == 3) r_empty = ($urandom_range(7) == 0) ? 6'h3F : 6'h3E;
            else              r_empty = ($urandom_range(39) == 0) ? 6'h3B : 6'h3F;
            step($urandom_range(49) == 0, $urandom_range(1999) == 0, t_level,
                 $urandom_range(3) != 0, r_full, r_empty);
        end

`ifdef CAPTURE_TIMESTAMP_EN
        // Trigger pin rises 100 cycles after reset; stamp is taken 3 cycles later
        do_reset();
        step(1, 0, 0, 0, 6'h00, 6'h3F);
        while (m_cycles < 32'd100) step(0, 0, 0, 0, 6'h00, 6'h3F);
        t_cyc = m_cycles;
        repeat (2) step(0, 0, 1, 0, 6'h00, 6'h3F);
        repeat (4) step(0, 0, 0, 0, 6'h00, 6'h3F);
        chk("ts_fixed_offset", bus.trig_timestamp, t_cyc + 32'd3);
        repeat (3) step(0, 0, 1, 1, 6'h00, 6'h3F);
        repeat (6) step(0, 0, 0, 1, 6'h00, 6'h3F);
        chk("ts_stable", bus.trig_timestamp, t_cyc + 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
